// File: rtl/av_token_scheduler.sv
// av_token_scheduler: walks the A*V multiply engine across every token of one
// attention head, one engine invocation per token, using the precision code
// for that token from a snapshot of prec_map. It also counts issued tokens
// per precision and guards each invocation with a watchdog.
//
// Optional feature macro: AV_SCHED_SKIP_EN
//   defined   : tokens coded 2'b11 (pruned) are skipped without an engine start
//               and counted in cnt_skip.
//   undefined : code 2'b11 is issued as FP16 (2'b10) and cnt_skip stays 0.
module av_token_scheduler #(
  parameter int NUM_TOKENS     = 8,
  parameter int IDX_W          = $clog2(NUM_TOKENS),
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2*NUM_TOKENS-1:0] prec_map,
  output logic                    eng_start,
  output logic [1:0]              eng_precision_sel,
  output logic [IDX_W-1:0]        eng_token_idx,
  input  logic                    eng_done,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [CNT_W-1:0]        cnt_int4,
  output logic [CNT_W-1:0]        cnt_int8,
  output logic [CNT_W-1:0]        cnt_fp16,
  output logic [CNT_W-1:0]        cnt_skip
);

`ifdef AV_SCHED_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  localparam int               WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TOKENS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]  WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  // Precision code the engine sees for token i; pruned folds to FP16 when
  // skipping is not built in, so the engine never receives 2'b11.
  function automatic logic [1:0] token_code(input logic [2*NUM_TOKENS-1:0] map,
                                            input logic [IDX_W-1:0]        i);
    logic [1:0] raw;
    raw = map[{i, 1'b0} +: 2];
    if (!SKIP_EN && (raw == 2'b11)) begin
      token_code = 2'b10;
    end else begin
      token_code = raw;
    end
  endfunction

  // A token is skipped only when the feature is built in and it is pruned.
  function automatic logic is_skip(input logic [1:0] code);
    is_skip = SKIP_EN && (code == 2'b11);
  endfunction

  // Saturating increment so the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t                  state_r, next_state_s;
  logic [IDX_W-1:0]        idx_r, next_idx_s;
  logic [2*NUM_TOKENS-1:0] snap_r;
  logic [WD_W-1:0]         wdog_r;
  logic                    load_s;
  logic                    timeout_hit_s;
  logic [1:0]              issue_code_s;

  // Next-state decode plus the precision of whichever token will be issued next.
  always_comb begin
    next_state_s  = state_r;
    next_idx_s    = idx_r;
    load_s        = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_ISSUE;
          next_idx_s   = '0;
          load_s       = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (is_skip(eng_precision_sel)) begin
          next_state_s = S_NEXT;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        // eng_done takes priority over an expiring watchdog
        if (eng_done) begin
          next_state_s = S_NEXT;
        end else if (wdog_r == WD_LAST) begin
          next_state_s  = S_ABORT;
          timeout_hit_s = 1'b1;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_NEXT: begin
        if (idx_r == IDX_LAST) begin
          next_state_s = S_FINISH;
        end else begin
          next_state_s = S_ISSUE;
          next_idx_s   = idx_r + IDX_ONE;
        end
      end
      S_FINISH: next_state_s = S_IDLE;
      S_ABORT:  next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
    // On the accepting cycle the snapshot is not loaded yet, so read the port.
    if (load_s) begin
      issue_code_s = token_code(prec_map, next_idx_s);
    end else begin
      issue_code_s = token_code(snap_r, next_idx_s);
    end
  end

  // State, snapshot, watchdog and the registered engine/handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r           <= S_IDLE;
      idx_r             <= '0;
      snap_r            <= '0;
      wdog_r            <= '0;
      eng_start         <= 1'b0;
      eng_precision_sel <= 2'b00;
      eng_token_idx     <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      idx_r     <= next_idx_s;
      busy      <= (next_state_s != S_IDLE);
      done      <= (next_state_s == S_FINISH) || (next_state_s == S_ABORT);
      eng_start <= (next_state_s == S_ISSUE) && !is_skip(issue_code_s);
      if (load_s) begin
        snap_r <= prec_map;
      end
      if (next_state_s == S_ISSUE) begin
        eng_precision_sel <= issue_code_s;
        eng_token_idx     <= next_idx_s;
      end
      if (state_r == S_WAIT) begin
        wdog_r <= wdog_r + WD_ONE;
      end else begin
        wdog_r <= '0;
      end
      if (load_s) begin
        timeout_err <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Per-precision issue counters: cleared by an accepted start, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_int4 <= '0;
      cnt_int8 <= '0;
      cnt_fp16 <= '0;
    end else if (load_s) begin
      cnt_int4 <= '0;
      cnt_int8 <= '0;
      cnt_fp16 <= '0;
    end else if (state_r == S_ISSUE) begin
      case (eng_precision_sel)
        2'b00:   cnt_int4 <= sat_inc(cnt_int4);
        2'b01:   cnt_int8 <= sat_inc(cnt_int8);
        2'b10:   cnt_fp16 <= sat_inc(cnt_fp16);
        default: cnt_fp16 <= cnt_fp16;
      endcase
    end
  end

`ifdef AV_SCHED_SKIP_EN
  // Skipped-token counter, bumped in the ISSUE cycle of a pruned token.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_skip <= '0;
    end else if (load_s) begin
      cnt_skip <= '0;
    end else if ((state_r == S_ISSUE) && is_skip(eng_precision_sel)) begin
      cnt_skip <= sat_inc(cnt_skip);
    end
  end
`else
  assign cnt_skip = '0;
`endif

endmodule

// File: tb/tb_av_token_scheduler.sv
// Scoreboard bench for av_token_scheduler: directed runs push expected engine
// issues and done-time counter values; a monitor pops and compares them.
module tb_av_token_scheduler;
  localparam int NT    = 8;
  localparam int IDX_W = 3;
  localparam int TO    = 64;
  localparam int CW    = 16;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [2*NT-1:0]  prec_map;
  logic             eng_start, eng_done, busy, done, timeout_err;
  logic [1:0]       eng_precision_sel;
  logic [IDX_W-1:0] eng_token_idx;
  logic [CW-1:0]    cnt_int4, cnt_int8, cnt_fp16, cnt_skip;
  logic             eng_done_m, eng_done_f;

  assign eng_done = eng_done_m | eng_done_f;

  av_token_scheduler #(.NUM_TOKENS(NT), .IDX_W(IDX_W), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prec_map(prec_map),
    .eng_start(eng_start), .eng_precision_sel(eng_precision_sel),
    .eng_token_idx(eng_token_idx), .eng_done(eng_done), .busy(busy), .done(done),
    .timeout_err(timeout_err), .cnt_int4(cnt_int4), .cnt_int8(cnt_int8),
    .cnt_fp16(cnt_fp16), .cnt_skip(cnt_skip)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int prec; } iss_t;
  typedef struct { int c4; int c8; int c16; int cs; int terr; } dn_t;
  iss_t iss_q[$];
  dn_t  dn_q[$];

  int n_cmp = 0, n_bad = 0;
  int last_idx = -1, last_prec = -1;
  int hang_idx = -1, slow_idx = -1, slow_dly = 2, eng_cnt = 0;
  int mid_start_k = -1, force_done_k = -1, alt_map_k = -1;
  logic [2*NT-1:0] alt_map = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_issue(input int idx, input int prec);
    iss_t e;
    e.idx = idx; e.prec = prec;
    iss_q.push_back(e);
  endtask

  task automatic push_done(input int c4, input int c8, input int c16, input int cs, input int terr);
    dn_t d;
    d.c4 = c4; d.c8 = c8; d.c16 = c16; d.cs = cs; d.terr = terr;
    dn_q.push_back(d);
  endtask

  // Engine model: eng_done 2 cycles after eng_start (slow_dly for slow_idx, never for hang_idx).
  always @(negedge clk) begin
    eng_done_m = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done_m = 1'b1;
        if (busy === 1'b1) begin
          chk("wait_hold_idx", 32'(eng_token_idx), last_idx);
          chk("wait_hold_prec", 32'(eng_precision_sel), last_prec);
        end
      end
    end
    if (eng_start === 1'b1 && int'(eng_token_idx) != hang_idx)
      eng_cnt = (int'(eng_token_idx) == slow_idx) ? slow_dly : 2;
  end

  // Monitor: every eng_start and every done pulse consumes one expectation.
  always @(negedge clk) begin
    iss_t e;
    dn_t  d;
    if (eng_start === 1'b1) begin
      if (iss_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_eng_start: got idx %0d, expected no issue", eng_token_idx);
      end else begin
        e = iss_q.pop_front();
        chk("issue_idx", 32'(eng_token_idx), e.idx);
        chk("issue_prec", 32'(eng_precision_sel), e.prec);
        last_idx = e.idx; last_prec = e.prec;
      end
    end
    if (done === 1'b1) begin
      if (dn_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else begin
        d = dn_q.pop_front();
        chk("done_cnt_int4", 32'(cnt_int4), d.c4);
        chk("done_cnt_int8", 32'(cnt_int8), d.c8);
        chk("done_cnt_fp16", 32'(cnt_fp16), d.c16);
        chk("done_cnt_skip", 32'(cnt_skip), d.cs);
        chk("done_timeout_err", 32'(timeout_err), d.terr);
      end
    end
  end

  // One head run: start pulse, then count cycles to done (or stop early at stop_k).
  task automatic run_head(input logic [2*NT-1:0] map, input int exp_k, input int stop_k, input string nm);
    int k, busy_bad;
    bit seen;
    k = 0; busy_bad = 0; seen = 1'b0;
    prec_map = map;
    start = 1'b1;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      start      = (k == mid_start_k);
      eng_done_f = (k == force_done_k);
      if (k == alt_map_k) prec_map = alt_map;
      if (k == 1) begin
        chk({nm, "_terr_clear"}, 32'(timeout_err), 0);
        chk({nm, "_cnt_clear"}, 32'(cnt_int4) + 32'(cnt_int8) + 32'(cnt_fp16) + 32'(cnt_skip), 0);
      end
      if (k == stop_k) return;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    eng_done_f = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_no_done: got no done in %0d cycles, expected done at %0d", nm, k, exp_k);
    end else begin
      chk({nm, "_cycles"}, k, exp_k);
    end
    chk({nm, "_busy"}, busy_bad, 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_eng_start"}, 32'(eng_start), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_timeout_err"}, 32'(timeout_err), 0);
    chk({nm, "_cnt_int4"}, 32'(cnt_int4), 0);
    chk({nm, "_cnt_int8"}, 32'(cnt_int8), 0);
    chk({nm, "_cnt_fp16"}, 32'(cnt_fp16), 0);
    chk({nm, "_cnt_skip"}, 32'(cnt_skip), 0);
    chk({nm, "_prec_sel"}, 32'(eng_precision_sel), 0);
    chk({nm, "_token_idx"}, 32'(eng_token_idx), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no end of run, expected $finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; prec_map = '0; eng_done_f = 1'b0; eng_done_m = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All INT4, 2-cycle engine: 8 tokens x 4 cycles + FINISH
    for (int i = 0; i < NT; i++) push_issue(i, 0);
    push_done(8, 0, 0, 0, 0);
    run_head(16'h0000, 33, 0, "allint4");
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_hold_idx", 32'(eng_token_idx), 7);
    chk("idle_hold_prec", 32'(eng_precision_sel), 0);
    chk("idle_hold_cnt_int4", 32'(cnt_int4), 8);

    // Mixed map: codes per token 00,01,10,11,00,01,10,11
`ifdef AV_SCHED_SKIP_EN
    push_issue(0, 0); push_issue(1, 1); push_issue(2, 2);
    push_issue(4, 0); push_issue(5, 1); push_issue(6, 2);
    push_done(2, 2, 2, 2, 0);
    run_head(16'b11_10_01_00_11_10_01_00, 29, 0, "mixed");
`else
    push_issue(0, 0); push_issue(1, 1); push_issue(2, 2); push_issue(3, 2);
    push_issue(4, 0); push_issue(5, 1); push_issue(6, 2); push_issue(7, 2);
    push_done(2, 2, 4, 0, 0);
    run_head(16'b11_10_01_00_11_10_01_00, 33, 0, "mixed");
`endif
    @(negedge clk);
    chk("mixed_idle_idx", 32'(eng_token_idx), 7);

    // Engine hangs on token 3: 12 + ISSUE + 64 WAIT + ABORT
    for (int i = 0; i < 4; i++) push_issue(i, 0);
    push_done(4, 0, 0, 0, 1);
    hang_idx = 3;
    run_head(16'h0000, 78, 0, "timeout");
    hang_idx = -1;
    @(negedge clk);
    chk("timeout_sticky", 32'(timeout_err), 1);
    chk("timeout_idle_busy", 32'(busy), 0);

    // eng_done in IDLE and ISSUE, start mid-run: all ignored
    eng_done_f = 1'b1;
    @(negedge clk);
    eng_done_f = 1'b0;
    chk("idle_done_ignored_busy", 32'(busy), 0);
    mid_start_k = 10; force_done_k = 5;
    for (int i = 0; i < NT; i++) push_issue(i, 1);
    push_done(0, 8, 0, 0, 0);
    run_head(16'h5555, 33, 0, "ignore");
    mid_start_k = -1; force_done_k = -1;
    @(negedge clk);

    // eng_done exactly on the last watchdog cycle wins: token 2 waits 64 cycles
    slow_idx = 2; slow_dly = 64;
    for (int i = 0; i < NT; i++) push_issue(i, 0);
    push_done(8, 0, 0, 0, 0);
    run_head(16'h0000, 95, 0, "wd_edge");
    slow_idx = -1; slow_dly = 2;
    @(negedge clk);

    // Reset during WAIT of token 5 (first WAIT cycle is k=22)
    for (int i = 0; i < 6; i++) push_issue(i, 2);
    run_head(16'hAAAA, 0, 22, "rstwait");
    chk("rstwait_idx", 32'(eng_token_idx), 5);
    chk("rstwait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrun_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // prec_map changed right after start: latched INT8 must be used, from token 0
    alt_map_k = 1; alt_map = 16'h0000;
    for (int i = 0; i < NT; i++) push_issue(i, 1);
    push_done(0, 8, 0, 0, 0);
    run_head(16'h5555, 33, 0, "latch");
    alt_map_k = -1;
    repeat (2) @(negedge clk);

    chk("issue_queue_empty", iss_q.size(), 0);
    chk("done_queue_empty", dn_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
